target_box_extract: RTL
=======================

# target_box_extract

Extracts up to ten target bounding boxes from the binarised pixel stream and publishes them once per frame. It sits directly upstream of the overlay/rectangle-drawing stage and feeds that stage's `target_xy` box array and `target_out` centre array. Pixels are merged into boxes by a proximity rule while the frame is scanned. Qualifying boxes are compacted and committed atomically during vertical blanking.

## Interface
- `IMG_HDISP`, 12'd1280, active pixels per line
- `IMG_VDISP`, 12'd720, active lines per frame
- `GAP`, 12'd16, merge distance in pixels
- `MIN_W`, 12'd4, minimum published box width
- `MIN_H`, 12'd4, minimum published box height

Ports:
- `clk` in 1: clock
- `rst_n` in 1: reset, asynchronous, active-low
- `per_frame_vsync` in 1: frame sync; a rising edge marks frame start
- `per_frame_href` in 1: line valid; informational only
- `per_frame_clken` in 1: pixel strobe
- `per_img_Bit` in 1: binary pixel, 1 = foreground
- `target_xy[9:0]` out 48 each: {up[47:36], down[35:24], left[23:12], right[11:0]}
- `target_out[9:0]` out 24 each: {cx[23:12], cy[11:0]}
- `target_valid` out 10: per-entry valid
- `target_cnt` out 4: number of published boxes, 0–10
- `target_ovf` out 1: previous frame had more blobs than slots
- `frame_done` out 1: one-cycle pulse when outputs are committed

## Operation
- Vsync rising edge: `rise = per_frame_vsync & ~vsync_r`.
- Pixel counters `x` and `y`:
  - Cleared on `rise`.
  - On `clken`, `x` increments; at `IMG_HDISP-1`, `x` wraps to 0 and `y` increments.
- Pixel stage: `{bit, x, y}` is registered on `clken`. The registered pixel updates the slots on the next edge.
- Working set: 10 slots, each holding `{valid, left, right, up, down}`, all 12 bits.
- A foreground pixel hits slot i if slot i is valid and all of the following hold:
  - `x >= sat(left-GAP)`
  - `x <= sat(right+GAP)`
  - `y >= sat(up-GAP)`
  - `y <= sat(down+GAP)`
  - `sat` clamps to the range 0..4095.
- Slot update for a foreground pixel:
  - Hit: the lowest-index hit slot expands: `left=min(left,x)`, `right=max(right,x)`, `up=min`, `down=max`.
  - No hit, a free slot exists: the lowest free slot is allocated as the point box.
  - No hit, slots full: the pixel is dropped and the frame `ovf` flag is set.
- Boxes are never merged with each other after allocation.
- FSM states:
  - `IDLE`: entered on reset. Pixels are ignored. On `rise`: clear the slots, go to `ACCUM`. Nothing is published.
  - `ACCUM`: slot updates are active. On `rise`: go to `PUBLISH` with `idx=0`, `k=0`.
  - `PUBLISH`: one slot per cycle, `idx` running 0..9.
    - If the slot is valid, `right-left+1 >= MIN_W` and `down-up+1 >= MIN_H`, it is copied into shadow entry k and k is incremented.
    - The slot is cleared after reading.
    - At `idx==9`, go to `COMMIT`.
  - `COMMIT`: the shadow is copied to the outputs; `target_cnt=k`, `target_ovf` is set from the frame flag, `frame_done=1`. The flag is cleared and the FSM goes to `ACCUM`.
- Shadow entries not written in a publish pass are zero, with `valid=0`.
- Centre: `cx=(left+right)>>1` and `cy=(up+down)>>1`, computed with 13-bit sums and truncated to 12 bits.
- `clken` pulses during `PUBLISH` or `COMMIT` are ignored. The counters still run from the rise.
- Reset: all outputs are 0 and all slots are invalid. The FSM enters `IDLE`.

## Timing
- Slot latency: a pixel sampled at edge n updates its slot at edge n+1.
- A pixel sampled at the edge just before E0 is still applied at E0.
- Publish sequence:
  - E0 is the edge that samples `rise`; the FSM enters `PUBLISH`.
  - E1..E10 process slots 0..9.
  - E11 commits: outputs, `target_cnt` and `target_ovf` change, and `frame_done=1`.
  - E12: `frame_done` returns to 0.
- Outputs hold constant between commits.
- Blanking: the source guarantees at least 12 clocks from the vsync rise to the first `clken`.
- Reset asserted mid-`PUBLISH`: outputs go to 0 immediately. The next `rise` goes `IDLE`→`ACCUM` without publishing.

## Test plan
- 20×10 block at x=100..119, y=200..209:
  - `target_xy[0]={200,209,100,119}`
  - `target_out[0]={109,204}`
  - `valid=10'b1`, `cnt=1`
  - `frame_done` pulses at E11 only.
- Merge rule: two 8×8 blocks with a 10-pixel horizontal gap produce one box. The same blocks with a 30-pixel gap produce two boxes, at index 0 (left) and index 1.
- Eleven separated 8×8 blocks in raster order: `cnt=10`, `ovf=1`, the last block is absent. A following empty frame gives `cnt=0`, `ovf=0`.
- Size filter and compaction: a 2×2 block (slot 0) and a 10×10 block (slot 1) publish only the 10×10 box at index 0. Entries 1..9 are zero and `cnt=1`.
- Empty frame: all outputs are zero, `cnt=0`, and `frame_done` still pulses.
- `rst_n` low during `PUBLISH`: all outputs are 0. The next vsync rise produces no `frame_done`. The following frame's boxes publish normally.

Source files
------------

// File: rtl/target_box_extract.sv
// target_box_extract
//   Scans a binarised pixel stream, grows up to ten bounding boxes with a
//   proximity rule while the frame is active, then during vertical blanking
//   filters/compacts the boxes and commits them to the outputs atomically.
//
//   clk, rst_n         clock, asynchronous active-low reset
//   per_frame_vsync    frame sync, rising edge = frame start
//   per_frame_href     line valid (informational only)
//   per_frame_clken    pixel strobe
//   per_img_Bit        binary pixel, 1 = foreground
//   target_xy[i]       {up, down, left, right}, 12 bits each
//   target_out[i]      {cx, cy} box centre
//   target_valid       per-entry valid
//   target_cnt         number of published boxes (0..10)
//   target_ovf         previous frame had more blobs than slots
//   frame_done         one-cycle pulse on commit
module target_box_extract #(
   parameter logic [11:0] IMG_HDISP = 12'd1280,
   parameter logic [11:0] IMG_VDISP = 12'd720,
   parameter logic [11:0] GAP       = 12'd16,
   parameter logic [11:0] MIN_W     = 12'd4,
   parameter logic [11:0] MIN_H     = 12'd4
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              per_frame_vsync,
   input  logic              per_frame_href,
   input  logic              per_frame_clken,
   input  logic              per_img_Bit,
   output logic [9:0][47:0]  target_xy,
   output logic [9:0][23:0]  target_out,
   output logic [9:0]        target_valid,
   output logic [3:0]        target_cnt,
   output logic              target_ovf,
   output logic              frame_done
);

   typedef enum logic [1:0] {IDLE, ACCUM, PUBLISH, COMMIT} state_t;

   state_t state_q, state_d;

   logic        vsync_r;
   logic        rise;
   logic [11:0] x_cnt, y_cnt;

   logic        pix_vld;
   logic [11:0] pix_x, pix_y;

   logic [9:0]  s_valid;
   logic [11:0] s_left  [10];
   logic [11:0] s_right [10];
   logic [11:0] s_up    [10];
   logic [11:0] s_down  [10];

   logic [9:0]        hit;
   logic              hit_any, free_any;
   logic [3:0]        hit_idx, free_idx;

   logic [9:0][47:0]  sh_xy;
   logic [9:0][23:0]  sh_ctr;
   logic [9:0]        sh_valid;
   logic [3:0]        idx_q, k_q;
   logic              ovf_flag;

   logic [11:0]       rd_l, rd_r, rd_u, rd_d;
   logic              qual;

   logic unused_ok;
   assign unused_ok = per_frame_href ^ (^IMG_VDISP);

   function automatic logic [11:0] sat_sub(input logic [11:0] a, input logic [11:0] b);
      return (a < b) ? '0 : a - b;
   endfunction

   function automatic logic [11:0] sat_add(input logic [11:0] a, input logic [11:0] b);
      logic [12:0] s;
      s = {1'b0, a} + {1'b0, b};
      return s[12] ? '1 : s[11:0];
   endfunction

   assign rise = per_frame_vsync & ~vsync_r;

   // ---------------------------------------------------------------- FSM
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (rise) state_d = ACCUM;
         ACCUM:   if (rise) state_d = PUBLISH;
         PUBLISH: if (idx_q == 4'd9) state_d = COMMIT;
         COMMIT:  state_d = ACCUM;
         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------- counters / pixel
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         vsync_r <= 1'b0;
         x_cnt   <= '0;
         y_cnt   <= '0;
         pix_vld <= 1'b0;
         pix_x   <= '0;
         pix_y   <= '0;
      end else begin
         vsync_r <= per_frame_vsync;
         if (rise) begin
            x_cnt <= '0;
            y_cnt <= '0;
         end else if (per_frame_clken) begin
            if (x_cnt == IMG_HDISP - 12'd1) begin
               x_cnt <= '0;
               y_cnt <= y_cnt + 12'd1;
            end else begin
               x_cnt <= x_cnt + 12'd1;
            end
         end
         // Only pixels strobed while accumulating ever reach the slots.
         pix_vld <= per_frame_clken & per_img_Bit & (state_q == ACCUM);
         if (per_frame_clken) begin
            pix_x <= x_cnt;
            pix_y <= y_cnt;
         end
      end
   end

   // ------------------------------------------------------- hit detection
   for (genvar g = 0; g < 10; g++) begin : g_hit
      assign hit[g] = s_valid[g] &&
                      (pix_x >= sat_sub(s_left[g], GAP))  &&
                      (pix_x <= sat_add(s_right[g], GAP)) &&
                      (pix_y >= sat_sub(s_up[g], GAP))    &&
                      (pix_y <= sat_add(s_down[g], GAP));
   end

   always_comb begin
      hit_any  = 1'b0;
      hit_idx  = '0;
      free_any = 1'b0;
      free_idx = '0;
      for (int unsigned i = 0; i < 10; i++) begin
         if (hit[i] && !hit_any) begin
            hit_any = 1'b1;
            hit_idx = i[3:0];
         end
         if (!s_valid[i] && !free_any) begin
            free_any = 1'b1;
            free_idx = i[3:0];
         end
      end
   end

   // ------------------------------------------------------------ slots
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         s_valid  <= '0;
         ovf_flag <= 1'b0;
         for (int unsigned i = 0; i < 10; i++) begin
            s_left[i]  <= '0;
            s_right[i] <= '0;
            s_up[i]    <= '0;
            s_down[i]  <= '0;
         end
      end else begin
         case (state_q)
            IDLE: begin
               if (rise) begin
                  s_valid  <= '0;
                  ovf_flag <= 1'b0;
               end
            end
            ACCUM: begin
               // A pixel registered just before the rise is still applied here.
               if (pix_vld) begin
                  if (hit_any) begin
                     if (pix_x < s_left[hit_idx])  s_left[hit_idx]  <= pix_x;
                     if (pix_x > s_right[hit_idx]) s_right[hit_idx] <= pix_x;
                     if (pix_y < s_up[hit_idx])    s_up[hit_idx]    <= pix_y;
                     if (pix_y > s_down[hit_idx])  s_down[hit_idx]  <= pix_y;
                  end else if (free_any) begin
                     s_valid[free_idx] <= 1'b1;
                     s_left[free_idx]  <= pix_x;
                     s_right[free_idx] <= pix_x;
                     s_up[free_idx]    <= pix_y;
                     s_down[free_idx]  <= pix_y;
                  end else begin
                     ovf_flag <= 1'b1;
                  end
               end
            end
            PUBLISH: begin
               s_valid[idx_q] <= 1'b0;
               s_left[idx_q]  <= '0;
               s_right[idx_q] <= '0;
               s_up[idx_q]    <= '0;
               s_down[idx_q]  <= '0;
            end
            COMMIT: ovf_flag <= 1'b0;
            default: ;
         endcase
      end
   end

   // --------------------------------------------------- publish / shadow
   assign rd_l = s_left[idx_q];
   assign rd_r = s_right[idx_q];
   assign rd_u = s_up[idx_q];
   assign rd_d = s_down[idx_q];
   assign qual = s_valid[idx_q] &&
                 (rd_r - rd_l + 12'd1 >= MIN_W) &&
                 (rd_d - rd_u + 12'd1 >= MIN_H);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sh_xy    <= '0;
         sh_valid <= '0;
         idx_q    <= '0;
         k_q      <= '0;
      end else begin
         if (state_q == ACCUM && rise) begin
            sh_xy    <= '0;
            sh_valid <= '0;
            idx_q    <= '0;
            k_q      <= '0;
         end else if (state_q == PUBLISH) begin
            idx_q <= idx_q + 4'd1;
            if (qual) begin
               sh_xy[k_q]    <= {rd_u, rd_d, rd_l, rd_r};
               sh_valid[k_q] <= 1'b1;
               k_q           <= k_q + 4'd1;
            end
         end
      end
   end

   for (genvar g = 0; g < 10; g++) begin : g_ctr
      logic [12:0] sum_lr, sum_ud;
      assign sum_lr    = {1'b0, sh_xy[g][23:12]} + {1'b0, sh_xy[g][11:0]};
      assign sum_ud    = {1'b0, sh_xy[g][47:36]} + {1'b0, sh_xy[g][35:24]};
      assign sh_ctr[g] = {sum_lr[12:1], sum_ud[12:1]};
   end

   // ------------------------------------------------------------ outputs
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         target_xy    <= '0;
         target_out   <= '0;
         target_valid <= '0;
         target_cnt   <= '0;
         target_ovf   <= 1'b0;
         frame_done   <= 1'b0;
      end else begin
         frame_done <= 1'b0;
         if (state_q == COMMIT) begin
            target_xy    <= sh_xy;
            target_out   <= sh_ctr;
            target_valid <= sh_valid;
            target_cnt   <= k_q;
            target_ovf   <= ovf_flag;
            frame_done   <= 1'b1;
         end
      end
   end

endmodule
